instr_mem_bank: RTL and testbench
=================================

INSTR_MEM_BANK -- requirements
Module: instr_mem_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter DEPTH, default 64, word count; power of two, 4..1024.
REQ-003 SHALL have parameter BYTE_ADDR, default 1; 1 means fetch_addr is a byte address, 0 means a word index.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port fetch_addr  in  32  PC from fetch stage.
REQ-007 SHALL have port fetch_en  in  1  1 = advance output; 0 = stall, hold instr.
REQ-008 SHALL have port flush  in  1  replace next output with NOP (all zeros).
REQ-009 SHALL have port load_start  in  1  debug unit: begin load, or terminate an active load.
REQ-010 SHALL have ports load_valid  in  1  and load_data  in  DATA_W, the debug-unit write word.
REQ-011 SHALL have port load_ready  out  1  block accepts a load word this cycle.
REQ-012 SHALL have port load_done  out  1  one-cycle pulse when a load completes.
REQ-013 SHALL have port load_count  out  clog2(DEPTH)+1  words written by the last or current load.
REQ-014 SHALL have ports instr  out  DATA_W  and instr_valid  out  1  fetched word and its qualifier.
REQ-015 SHALL have port addr_err  out  1  current instr came from an out-of-range address.

Function
REQ-016 SHALL implement FSM IDLE, LOAD, DONE, RUN; IDLE->LOAD on load_start; LOAD->DONE on full or load_start; DONE->RUN unconditionally after 1 cycle; RUN->LOAD on load_start.
REQ-017 SHALL assert load_ready only in LOAD; each cycle with load_valid&&load_ready writes load_data to mem[wr_ptr] and increments wr_ptr and load_count.
REQ-018 SHALL enter DONE on the cycle after the write at wr_ptr==DEPTH-1 (full); further load_valid is ignored.
REQ-019 SHALL give load_start priority over load_valid in LOAD: the word in that cycle is not written, and the FSM enters DONE.
REQ-020 SHALL, on entry to LOAD, clear wr_ptr and load_count to 0; memory words beyond the new load keep their old contents.
REQ-021 SHALL pulse load_done high exactly in DONE.
REQ-022 SHALL derive the word index as fetch_addr[clog2(DEPTH)+1:2] when BYTE_ADDR=1, else fetch_addr[clog2(DEPTH)-1:0].
REQ-023 SHALL flag out of range when the upper address bits beyond the index (bits [1:0] excluded when BYTE_ADDR=1) are nonzero; the word output is NOP with addr_err=1.
REQ-024 SHALL, in RUN with fetch_en=1, register mem[index] into instr with one-cycle latency and set instr_valid=1.
REQ-025 SHALL hold instr, instr_valid and addr_err unchanged when fetch_en=0 and flush=0.
REQ-026 SHALL, on flush, load NOP into instr with instr_valid=1 and addr_err=0 on the next edge, regardless of fetch_en (flush wins).
REQ-027 SHALL hold instr=0 and instr_valid=0 in IDLE, LOAD and DONE.

Reset
REQ-028 SHALL on rst force state=IDLE, wr_ptr=0, load_count=0, instr=0, instr_valid=0, addr_err=0, load_ready=0, load_done=0, halt=0.
REQ-029 SHALL not clear memory contents on reset; a reset mid-load aborts the load and keeps words already written.

Configuration
REQ-030 SHALL with macro INSTR_MEM_HALT_DETECT_EN add output halt (1 bit): set when a fetched instr equals all-ones in RUN; sticky until rst or LOAD entry; while halt=1 instr holds its value and instr_valid=0.
REQ-031 SHALL without INSTR_MEM_HALT_DETECT_EN omit the halt port; an all-ones word is passed through as a normal instruction.

Verification
REQ-032 SHALL check load: load_start, then 3 words 0x00221820, 0x00222022, 0x0C000006 -> load_start ends the load, load_count=3, load_done pulses 1 cycle, state RUN.
REQ-033 SHALL check fetch: BYTE_ADDR=1, fetch_addr=0x8, fetch_en=1 -> next cycle instr=0x0C000006, instr_valid=1; fetch_en=0 for 3 cycles -> instr unchanged.
REQ-034 SHALL check full: DEPTH=64, 64 words streamed with load_valid high -> 64th accepted, load_ready low next cycle, load_count=64, 65th word never written.
REQ-035 SHALL check boundaries: fetch_addr=0x100 (DEPTH=64) -> instr=0, addr_err=1; flush with fetch_en=1 -> instr=0, addr_err=0.
REQ-036 SHALL check reset mid-load: rst after 2 of 5 words -> all outputs at reset values; after a restarted load, words 0-1 read back as written.
REQ-037 SHALL check with INSTR_MEM_HALT_DETECT_EN: word 0xFFFFFFFF at index 4 fetched -> halt=1, instr_valid=0 until load_start.

Source files
------------

// File: rtl/instr_mem_bank.sv
// instr_mem_bank: instruction memory filled by a debug unit, read by the fetch stage.
// A debug unit streams words into consecutive memory slots during LOAD.
// The fetch stage reads one registered word per cycle in RUN.
// Optional feature macro: INSTR_MEM_HALT_DETECT_EN adds a sticky 'halt' output.
// 'halt' is raised when an all-ones word is fetched.
module instr_mem_bank #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int BYTE_ADDR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              fetch_addr,
  input  logic                     fetch_en,
  input  logic                     flush,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     load_ready,
  output logic                     load_done,
  output logic [$clog2(DEPTH):0]   load_count,
  output logic [DATA_W-1:0]        instr,
  output logic                     instr_valid,
  output logic                     addr_err
`ifdef INSTR_MEM_HALT_DETECT_EN
  ,
  output logic                     halt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, RUN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW:0]       r_load_count;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_instr;
  logic              r_instr_valid;
  logic              r_addr_err;
  logic              w_wr_en;
  logic              w_load_entry;
  logic [AW-1:0]     w_index;
  logic              w_oor;
  logic [DATA_W-1:0] w_rd_word;
`ifdef INSTR_MEM_HALT_DETECT_EN
  logic              r_halt;
`endif

  // A load word is taken only in LOAD, and load_start in the same cycle discards it.
  assign w_wr_en      = (r_state == LOAD) && load_valid && !load_start;
  assign w_load_entry = (w_next == LOAD) && (r_state != LOAD);

  generate
    if (BYTE_ADDR != 0) begin : g_byte_addr
      logic w_unused_lsb;
      assign w_unused_lsb = ^fetch_addr[1:0];
      assign w_index      = fetch_addr[AW+1:2];
      assign w_oor        = |fetch_addr[31:AW+2];
    end else begin : g_word_addr
      assign w_index = fetch_addr[AW-1:0];
      assign w_oor   = |fetch_addr[31:AW];
    end
  endgenerate

  assign w_rd_word = r_mem[w_index];

  // State register: reset returns to IDLE, aborting any load in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: load_start ends a load early, and the last slot written also ends it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (load_start) w_next = LOAD;
      LOAD: begin
        if (load_start)                          w_next = DONE;
        else if (w_wr_en && r_wr_ptr == LAST_PTR) w_next = DONE;
      end
      DONE: w_next = RUN;
      RUN:  if (load_start) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs are decoded directly from the current state.
  always_comb begin
    load_ready = 1'b0;
    load_done  = 1'b0;
    if (r_state == LOAD) load_ready = 1'b1;
    if (r_state == DONE) load_done  = 1'b1;
  end

  // Write pointer and word count restart at zero whenever a new load begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_load_count <= '0;
    end else if (w_load_entry) begin
      r_wr_ptr     <= '0;
      r_load_count <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr     <= r_wr_ptr + 1'b1;
      r_load_count <= r_load_count + 1'b1;
    end
  end

  // Memory array is deliberately not reset so a reset keeps the words already loaded.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= load_data;
  end

  // Fetch output register: it is zero outside RUN, flush beats fetch_en, and a stall holds the value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
`ifdef INSTR_MEM_HALT_DETECT_EN
      r_halt        <= 1'b0;
`endif
    end else if (r_state != RUN || w_next != RUN) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
`ifdef INSTR_MEM_HALT_DETECT_EN
      if (w_load_entry) r_halt <= 1'b0;
    end else if (r_halt) begin
      r_instr_valid <= 1'b0;
`endif
    end else if (flush) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b1;
      r_addr_err    <= 1'b0;
    end else if (fetch_en) begin
      if (w_oor) begin
        r_instr       <= '0;
        r_instr_valid <= 1'b1;
        r_addr_err    <= 1'b1;
      end else begin
        r_instr       <= w_rd_word;
        r_addr_err    <= 1'b0;
`ifdef INSTR_MEM_HALT_DETECT_EN
        if (w_rd_word == '1) begin
          r_instr_valid <= 1'b0;
          r_halt        <= 1'b1;
        end else begin
          r_instr_valid <= 1'b1;
        end
`else
        r_instr_valid <= 1'b1;
`endif
      end
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign addr_err    = r_addr_err;
  assign load_count  = r_load_count;
`ifdef INSTR_MEM_HALT_DETECT_EN
  assign halt        = r_halt;
`endif

endmodule

// File: tb/tb_instr_mem_bank.sv
// tb_instr_mem_bank: self-checking bench for instr_mem_bank (DATA_W=32, DEPTH=64, BYTE_ADDR=1).
// Fetch results are predicted into a scoreboard queue when the stimulus is driven.
// They are compared one cycle later, when the registered output appears.
// The halt scenario is checked against the behaviour selected by INSTR_MEM_HALT_DETECT_EN.
module tb_instr_mem_bank;

  typedef struct packed {
    logic [31:0] instr;
    logic        valid;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_addr;
  logic        fetch_en;
  logic        flush;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic [6:0]  load_count;
  logic [31:0] instr;
  logic        instr_valid;
  logic        addr_err;
`ifdef INSTR_MEM_HALT_DETECT_EN
  logic        halt;
`endif

  logic [31:0] modelMem [64];
  exp_t        sbQ [$];
  int          total = 0;
  int          bad   = 0;

  instr_mem_bank #(.DATA_W(32), .DEPTH(64), .BYTE_ADDR(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_addr (fetch_addr),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count),
    .instr      (instr),
    .instr_valid(instr_valid),
    .addr_err   (addr_err)
`ifdef INSTR_MEM_HALT_DETECT_EN
    ,
    .halt       (halt)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guards against a hang; the bench needs only a few thousand ns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mkExp(input logic [31:0] i, input logic v, input logic e);
    exp_t r;
    r.instr = i;
    r.valid = v;
    r.err   = e;
    return r;
  endfunction

  // Drive one fetch-side cycle and queue the result it should produce.
  task automatic applyStimulus(input logic [31:0] addr, input logic en, input logic fl, input exp_t e);
    fetch_addr = addr;
    fetch_en   = en;
    flush      = fl;
    sbQ.push_back(e);
  endtask

  // Drive one load-side cycle; the bench's memory model follows only writes it expects to be accepted.
  task automatic loadWord(input int idx, input logic [31:0] data);
    load_valid = 1'b1;
    load_data  = data;
    modelMem[idx] = data;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (instr !== 32'h0) begin bad++; $display("[TB] FAIL reset_instr: got %h expected 00000000", instr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
    total++; if (addr_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", addr_err); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 0", load_ready); end
    total++; if (load_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", load_done); end
    total++; if (load_count !== 7'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", load_count); end
`ifdef INSTR_MEM_HALT_DETECT_EN
    total++; if (halt !== 1'b0) begin bad++; $display("[TB] FAIL reset_halt: got %b expected 0", halt); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    total++; if (load_ready !== 1'b1) begin bad++; $display("[TB] FAIL load_ready_on: got %b expected 1", load_ready); end
    loadWord(0, 32'h00221820);
    loadWord(1, 32'h00222022);
    loadWord(2, 32'h0C000006);
    total++; if (load_count !== 7'd3) begin bad++; $display("[TB] FAIL load_count3: got %0d expected 3", load_count); end
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    total++; if (load_done !== 1'b1) begin bad++; $display("[TB] FAIL load_done_pulse: got %b expected 1", load_done); end
    total++; if (load_ready !== 1'b0) begin bad++; $display("[TB] FAIL load_ready_off: got %b expected 0", load_ready); end
    tick();
    total++; if (load_done !== 1'b0) begin bad++; $display("[TB] FAIL load_done_end: got %b expected 0", load_done); end
    total++; if (load_count !== 7'd3) begin bad++; $display("[TB] FAIL load_count_keep: got %0d expected 3", load_count); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL load_idle_valid: got %b expected 0", instr_valid); end
  endtask

  task automatic test_fetch();
    exp_t e;
    exp_t got;
    applyStimulus(32'h8, 1'b1, 1'b0, mkExp(32'h0C000006, 1'b1, 1'b0));
    tick();
    e = sbQ.pop_front();
    got = {instr, instr_valid, addr_err};
    total++; if (got !== e) begin bad++; $display("[TB] FAIL fetch_addr8: got %h/%b/%b expected %h/%b/%b", got.instr, got.valid, got.err, e.instr, e.valid, e.err); end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h0, 1'b0, 1'b0, mkExp(32'h0C000006, 1'b1, 1'b0));
      tick();
      e = sbQ.pop_front();
      got = {instr, instr_valid, addr_err};
      total++; if (got !== e) begin bad++; $display("[TB] FAIL fetch_stall%0d: got %h/%b/%b expected %h/%b/%b", i, got.instr, got.valid, got.err, e.instr, e.valid, e.err); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [5];
    exp_t e;
    exp_t got;
    addrs = '{32'h0, 32'h4, 32'h8, 32'h6, 32'h0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(addrs[i], 1'b1, 1'b0, mkExp(modelMem[addrs[i][7:2]], 1'b1, 1'b0));
      tick();
      e = sbQ.pop_front();
      got = {instr, instr_valid, addr_err};
      total++; if (got !== e) begin bad++; $display("[TB] FAIL b2b_%0d: got %h/%b/%b expected %h/%b/%b", i, got.instr, got.valid, got.err, e.instr, e.valid, e.err); end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_full();
    exp_t e;
    exp_t got;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      loadWord(i, 32'hA5000000 | i);
      if (i == 62) begin
        total++; if (load_ready !== 1'b1 || load_count !== 7'd63) begin bad++; $display("[TB] FAIL full_63: got ready=%b count=%0d expected ready=1 count=63", load_ready, load_count); end
      end
    end
    total++; if (load_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready: got %b expected 0", load_ready); end
    total++; if (load_count !== 7'd64) begin bad++; $display("[TB] FAIL full_count: got %0d expected 64", load_count); end
    total++; if (load_done !== 1'b1) begin bad++; $display("[TB] FAIL full_done: got %b expected 1", load_done); end
    load_valid = 1'b1;
    load_data  = 32'hDEADBEEF;
    tick();
    load_valid = 1'b0;
    total++; if (load_count !== 7'd64) begin bad++; $display("[TB] FAIL full_count_hold: got %0d expected 64", load_count); end
    applyStimulus(32'h0, 1'b1, 1'b0, mkExp(32'hA5000000, 1'b1, 1'b0));
    tick();
    e = sbQ.pop_front();
    got = {instr, instr_valid, addr_err};
    total++; if (got !== e) begin bad++; $display("[TB] FAIL full_word0: got %h/%b/%b expected %h/%b/%b", got.instr, got.valid, got.err, e.instr, e.valid, e.err); end
    applyStimulus(32'hFC, 1'b1, 1'b0, mkExp(32'hA500003F, 1'b1, 1'b0));
    tick();
    e = sbQ.pop_front();
    got = {instr, instr_valid, addr_err};
    total++; if (got !== e) begin bad++; $display("[TB] FAIL full_word63: got %h/%b/%b expected %h/%b/%b", got.instr, got.valid, got.err, e.instr, e.valid, e.err); end
    fetch_en = 1'b0;
  endtask

  task automatic test_bounds();
    logic [31:0] addrs [6];
    logic        ens   [6];
    logic        fls   [6];
    exp_t        exps  [6];
    exp_t        e;
    exp_t        got;
    addrs = '{32'h100, 32'h8, 32'hFC, 32'hFFFFFFFC, 32'h4, 32'h4};
    ens   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    fls   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exps  = '{mkExp(32'h0, 1'b1, 1'b1), mkExp(32'h0, 1'b1, 1'b0), mkExp(32'hA500003F, 1'b1, 1'b0),
              mkExp(32'h0, 1'b1, 1'b1), mkExp(32'h0, 1'b1, 1'b0), mkExp(32'h0, 1'b1, 1'b0)};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(addrs[i], ens[i], fls[i], exps[i]);
      tick();
      e = sbQ.pop_front();
      got = {instr, instr_valid, addr_err};
      total++; if (got !== e) begin bad++; $display("[TB] FAIL bounds_%0d: got %h/%b/%b expected %h/%b/%b", i, got.instr, got.valid, got.err, e.instr, e.valid, e.err); end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] addrs [3];
    exp_t e;
    exp_t got;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    loadWord(0, 32'h11111111);
    loadWord(1, 32'h22222222);
    load_valid = 1'b1;
    load_data  = 32'h33333333;
    #2;
    rst = 1'b1;
    #1;
    total++; if (load_count !== 7'd0) begin bad++; $display("[TB] FAIL midrst_count: got %0d expected 0", load_count); end
    total++; if (load_ready !== 1'b0 || load_done !== 1'b0) begin bad++; $display("[TB] FAIL midrst_hs: got ready=%b done=%b expected 0/0", load_ready, load_done); end
    total++; if ({instr, instr_valid, addr_err} !== 34'h0) begin bad++; $display("[TB] FAIL midrst_out: got %h/%b/%b expected 0/0/0", instr, instr_valid, addr_err); end
    load_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    load_start = 1'b1;
    tick();
    tick();
    load_start = 1'b0;
    total++; if (load_done !== 1'b1 || load_count !== 7'd0) begin bad++; $display("[TB] FAIL restart_done: got done=%b count=%0d expected 1/0", load_done, load_count); end
    tick();
    addrs = '{32'h0, 32'h4, 32'h8};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(addrs[i], 1'b1, 1'b0, mkExp(modelMem[i], 1'b1, 1'b0));
      tick();
      e = sbQ.pop_front();
      got = {instr, instr_valid, addr_err};
      total++; if (got !== e) begin bad++; $display("[TB] FAIL keep_word%0d: got %h/%b/%b expected %h/%b/%b", i, got.instr, got.valid, got.err, e.instr, e.valid, e.err); end
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_halt();
    exp_t e;
    exp_t got;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) loadWord(i, 32'h01000000 | i);
    loadWord(4, 32'hFFFFFFFF);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tick();
    applyStimulus(32'h4, 1'b1, 1'b0, mkExp(32'h01000001, 1'b1, 1'b0));
    tick();
    e = sbQ.pop_front();
    got = {instr, instr_valid, addr_err};
    total++; if (got !== e) begin bad++; $display("[TB] FAIL halt_pre: got %h/%b/%b expected %h/%b/%b", got.instr, got.valid, got.err, e.instr, e.valid, e.err); end
`ifdef INSTR_MEM_HALT_DETECT_EN
    applyStimulus(32'h10, 1'b1, 1'b0, mkExp(32'hFFFFFFFF, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sbQ.pop_front();
      got = {instr, instr_valid, addr_err};
      total++; if (got !== e || halt !== 1'b1) begin bad++; $display("[TB] FAIL halt_hold%0d: got %h/%b/%b halt=%b expected %h/%b/%b halt=1", i, got.instr, got.valid, got.err, halt, e.instr, e.valid, e.err); end
      applyStimulus(32'h0, 1'b1, 1'b0, mkExp(32'hFFFFFFFF, 1'b0, 1'b0));
    end
    void'(sbQ.pop_front());
    load_start = 1'b1;
    tick();
    total++; if (halt !== 1'b0) begin bad++; $display("[TB] FAIL halt_clear: got %b expected 0", halt); end
    tick();
    load_start = 1'b0;
    tick();
`else
    applyStimulus(32'h10, 1'b1, 1'b0, mkExp(32'hFFFFFFFF, 1'b1, 1'b0));
    tick();
    e = sbQ.pop_front();
    got = {instr, instr_valid, addr_err};
    total++; if (got !== e) begin bad++; $display("[TB] FAIL ones_pass: got %h/%b/%b expected %h/%b/%b", got.instr, got.valid, got.err, e.instr, e.valid, e.err); end
    applyStimulus(32'h0, 1'b1, 1'b0, mkExp(32'h01000000, 1'b1, 1'b0));
    tick();
    e = sbQ.pop_front();
    got = {instr, instr_valid, addr_err};
    total++; if (got !== e) begin bad++; $display("[TB] FAIL ones_next: got %h/%b/%b expected %h/%b/%b", got.instr, got.valid, got.err, e.instr, e.valid, e.err); end
`endif
    fetch_en = 1'b0;
  endtask

  // Scenario sequence, ending in the single summary line.
  initial begin
    rst        = 1'b1;
    fetch_addr = 32'h0;
    fetch_en   = 1'b0;
    flush      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'h0;
    test_reset();
    test_load();
    test_fetch();
    test_back_to_back();
    test_full();
    test_bounds();
    test_reset_mid_load();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
